// File: rtl/vdp_blender_pipe_if.sv
// Pixel bus for vdp_blender_pipe: input pixel/control and blended output.
// Master drives pixels, slave (the blender) returns blended colour.
interface vdp_blender_pipe_if #(
  parameter int COMPONENT_BITS = 4,
  parameter int ALPHA_BITS     = 4
);
  localparam int W = ALPHA_BITS + 3 * COMPONENT_BITS;

  logic         in_valid;
  logic         stall;
  logic         source_layer_enabled;
  logic [W-1:0] source_color;
  logic [W-1:0] dest_color;
  logic [1:0]   blend_mode;
  logic         out_valid;
  logic [W-1:0] output_color;

  modport master (
    output in_valid, stall, source_layer_enabled, source_color, dest_color, blend_mode,
    input  out_valid, output_color
  );

  modport slave (
    input  in_valid, stall, source_layer_enabled, source_color, dest_color, blend_mode,
    output out_valid, output_color
  );
endinterface

// File: rtl/vdp_blender_pipe.sv
// vdp_blender_pipe: 4-stage ARGB layer blender (S1 capture/weights, S2 multiply,
// S3 sum/clamp, S4 output). Output alpha is always the destination alpha.
// Optional feature macro VDP_BLENDER_MODES_EN: when defined, blend_mode selects
// alpha / additive / subtractive / source-over; when undefined only alpha
// blending is built and blend_mode is ignored (latency identical).
module vdp_blender_pipe #(
  parameter int COMPONENT_BITS = 4,
  parameter int ALPHA_BITS     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vdp_blender_pipe_if.slave    bus
);

  localparam int CB = COMPONENT_BITS;
  localparam int AB = ALPHA_BITS;
  localparam int W  = AB + 3 * CB;
  localparam int PW = CB + AB + 1;   // component * weight product
  localparam int SW = PW + 1;        // sum of two products plus rounding

  localparam logic [AB:0]   A_ONE = (AB+1)'(1) << AB;
  localparam logic [SW-1:0] ROUND = SW'(1) << (AB - 1);
  localparam logic [CB-1:0] CMAX  = '1;

`ifdef VDP_BLENDER_MODES_EN
  typedef enum logic [1:0] {
    MODE_ALPHA = 2'b00,
    MODE_ADD   = 2'b01,
    MODE_SUB   = 2'b10,
    MODE_OVER  = 2'b11
  } mode_e;
`endif

  // ---------------- input-side weights ----------------
  logic [AB-1:0] a_s, a_d;
  logic          vis_d;
  logic [AB:0]   ws_d, dv_d, wd_d;

  // Source visibility and the source/destination blend weights
  always_comb begin
    a_s   = bus.source_color[W-1 -: AB];
    a_d   = bus.dest_color[W-1 -: AB];
    vis_d = bus.source_layer_enabled && (a_s != '0);
    ws_d  = vis_d ? ({1'b0, a_s} + (AB+1)'(1)) : '0;
    dv_d  = (a_d != '0) ? ({1'b0, a_d} + (AB+1)'(1)) : '0;
    wd_d  = (AB+1)'(({(AB+1)'(0), A_ONE - ws_d} * {(AB+1)'(0), dv_d}) >> AB);
  end

  // ---------------- stage registers ----------------
  logic          s1_valid_q;
  logic [AB:0]   s1_ws_q, s1_wd_q;
  logic [AB-1:0] s1_a_q;
  logic [CB-1:0] s1_src_q [3];
  logic [CB-1:0] s1_dst_q [3];

  logic          s2_valid_q;
  logic [AB-1:0] s2_a_q;
  logic [PW-1:0] s2_ps_q [3];
  logic [PW-1:0] s2_pd_q [3];

`ifdef VDP_BLENDER_MODES_EN
  logic          s1_vis_q, s2_vis_q;
  mode_e         s1_mode_q, s2_mode_q;
  logic [CB-1:0] s2_src_q [3];
  logic [CB-1:0] s2_dst_q [3];
`endif

  logic          s3_valid_q;
  logic [W-1:0]  s3_color_d, s3_color_q;
  logic          out_valid_q;
  logic [W-1:0]  out_color_q;

  // S1: capture pixel, weights and mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_ws_q    <= '0;
      s1_wd_q    <= '0;
      s1_a_q     <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        s1_src_q[i] <= '0;
        s1_dst_q[i] <= '0;
      end
`ifdef VDP_BLENDER_MODES_EN
      s1_vis_q  <= 1'b0;
      s1_mode_q <= MODE_ALPHA;
`endif
    end else if (!bus.stall) begin
      s1_valid_q <= bus.in_valid;
      s1_ws_q    <= ws_d;
      s1_wd_q    <= wd_d;
      s1_a_q     <= a_d;
      for (int unsigned i = 0; i < 3; i++) begin
        s1_src_q[i] <= bus.source_color[i*CB +: CB];
        s1_dst_q[i] <= bus.dest_color[i*CB +: CB];
      end
`ifdef VDP_BLENDER_MODES_EN
      s1_vis_q  <= vis_d;
      s1_mode_q <= mode_e'(bus.blend_mode);
`endif
    end
  end

  // S2: per-component weighted products
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        s2_ps_q[i] <= '0;
        s2_pd_q[i] <= '0;
      end
`ifdef VDP_BLENDER_MODES_EN
      s2_vis_q  <= 1'b0;
      s2_mode_q <= MODE_ALPHA;
      for (int unsigned i = 0; i < 3; i++) begin
        s2_src_q[i] <= '0;
        s2_dst_q[i] <= '0;
      end
`endif
    end else if (!bus.stall) begin
      s2_valid_q <= s1_valid_q;
      s2_a_q     <= s1_a_q;
      for (int unsigned i = 0; i < 3; i++) begin
        s2_ps_q[i] <= PW'(s1_src_q[i]) * PW'(s1_ws_q);
        s2_pd_q[i] <= PW'(s1_dst_q[i]) * PW'(s1_wd_q);
      end
`ifdef VDP_BLENDER_MODES_EN
      s2_vis_q  <= s1_vis_q;
      s2_mode_q <= s1_mode_q;
      for (int unsigned i = 0; i < 3; i++) begin
        s2_src_q[i] <= s1_src_q[i];
        s2_dst_q[i] <= s1_dst_q[i];
      end
`endif
    end
  end

  // S3 combinational: rounded sum, clamp, and per-mode component select
  logic [CB+1:0] blend_sum [3];
  logic [CB-1:0] comp_alpha [3];
`ifdef VDP_BLENDER_MODES_EN
  logic [CB-1:0] s_eff [3];
  logic [CB:0]   add_sum [3];
  logic [CB-1:0] comp_res [3];
`endif

  // Blend each component and reassemble {A,R,G,B} with destination alpha
  always_comb begin
    s3_color_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      blend_sum[i]  = (CB+2)'((SW'(s2_ps_q[i]) + SW'(s2_pd_q[i]) + ROUND) >> AB);
      comp_alpha[i] = (blend_sum[i] > (CB+2)'(CMAX)) ? CMAX : blend_sum[i][CB-1:0];
`ifdef VDP_BLENDER_MODES_EN
      s_eff[i]   = s2_vis_q ? s2_src_q[i] : '0;
      add_sum[i] = {1'b0, s2_dst_q[i]} + {1'b0, s_eff[i]};
      comp_res[i] = comp_alpha[i];
      case (s2_mode_q)
        MODE_ADD:  comp_res[i] = add_sum[i][CB] ? CMAX : add_sum[i][CB-1:0];
        MODE_SUB:  comp_res[i] = (s2_dst_q[i] >= s_eff[i]) ? (s2_dst_q[i] - s_eff[i]) : '0;
        MODE_OVER: comp_res[i] = s2_vis_q ? s2_src_q[i] : s2_dst_q[i];
        default:   comp_res[i] = comp_alpha[i];
      endcase
      s3_color_d[i*CB +: CB] = comp_res[i];
`else
      s3_color_d[i*CB +: CB] = comp_alpha[i];
`endif
    end
    s3_color_d[W-1 -: AB] = s2_a_q;
  end

  // S3: register blended colour
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid_q <= 1'b0;
      s3_color_q <= '0;
    end else if (!bus.stall) begin
      s3_valid_q <= s2_valid_q;
      s3_color_q <= s3_color_d;
    end
  end

  // S4: output register; colour only advances on a valid pixel so bubbles hold it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_color_q <= '0;
    end else if (!bus.stall) begin
      out_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        out_color_q <= s3_color_q;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.output_color = out_color_q;

endmodule

// File: tb/tb_vdp_blender_pipe.sv
// Directed self-checking bench for vdp_blender_pipe (4/4 configuration).
// Expected colours are hand-computed for both the all-modes build and the
// alpha-only build.
module tb_vdp_blender_pipe;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  vdp_blender_pipe_if #(.COMPONENT_BITS(4), .ALPHA_BITS(4)) bus ();

  vdp_blender_pipe #(.COMPONENT_BITS(4), .ALPHA_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_px(input logic [1:0] mode, input logic en,
                          input logic [15:0] src, input logic [15:0] dst);
    bus.in_valid             = 1'b1;
    bus.blend_mode           = mode;
    bus.source_layer_enabled = en;
    bus.source_color         = src;
    bus.dest_color           = dst;
  endtask

  task automatic drive_idle();
    bus.in_valid             = 1'b0;
    bus.blend_mode           = 2'b00;
    bus.source_layer_enabled = 1'b0;
    bus.source_color         = '0;
    bus.dest_color           = '0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic        en;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] exp_modes;
    logic [15:0] exp_alpha;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  function automatic logic [15:0] expect_of(input vec_t v);
`ifdef VDP_BLENDER_MODES_EN
    return v.exp_modes;
`else
    return v.exp_alpha;
`endif
  endfunction

  initial begin
    logic [15:0] last_exp;

    //          mode   en    src      dst      modes    alpha-only
    vecs[0] = '{2'b00, 1'b1, 16'hFA50, 16'hF123, 16'hFA50, 16'hFA50};
    vecs[1] = '{2'b00, 1'b1, 16'h7C00, 16'hF400, 16'hF800, 16'hF800};
    vecs[2] = '{2'b01, 1'b1, 16'hFA00, 16'hF900, 16'hFF00, 16'hFA00};
    vecs[3] = '{2'b10, 1'b1, 16'hF300, 16'hF900, 16'hF600, 16'hF300};
    vecs[4] = '{2'b00, 1'b0, 16'hFFFF, 16'hF123, 16'hF123, 16'hF123};
    vecs[5] = '{2'b10, 1'b1, 16'hF500, 16'hF300, 16'hF000, 16'hF500};
    vecs[6] = '{2'b11, 1'b1, 16'h8ABC, 16'hF123, 16'hFABC, 16'hF678};
    vecs[7] = '{2'b11, 1'b1, 16'h0800, 16'hF123, 16'hF123, 16'hF123};
    vecs[8] = '{2'b00, 1'b1, 16'h7C00, 16'h0400, 16'h0600, 16'h0600};
    vecs[9] = '{2'b01, 1'b0, 16'hFFFF, 16'hF900, 16'hF900, 16'hF900};

    bus.stall = 1'b0;
    drive_idle();

    // Reset state
    #1;
    check_eq("reset_out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("reset_out_color", 32'(bus.output_color), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Back-to-back stream with per-pixel mode changes
    for (int t = 0; t < NV + 5; t++) begin
      @(negedge clk);
      if (t < 4) begin
        check_eq($sformatf("stream_lat_valid_%0d", t), 32'(bus.out_valid), 32'h0);
      end else if (t < NV + 4) begin
        check_eq($sformatf("stream_valid_%0d", t - 4), 32'(bus.out_valid), 32'h1);
        check_eq($sformatf("stream_color_%0d", t - 4), 32'(bus.output_color),
                 32'(expect_of(vecs[t-4])));
      end else begin
        check_eq("bubble_valid", 32'(bus.out_valid), 32'h0);
        check_eq("bubble_hold_color", 32'(bus.output_color), 32'(expect_of(vecs[NV-1])));
      end
      if (t < NV) drive_px(vecs[t].mode, vecs[t].en, vecs[t].src, vecs[t].dst);
      else        drive_idle();
    end
    last_exp = expect_of(vecs[NV-1]);

    // Stall of 3 cycles starting at cycle 2 while the pixel is in flight
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      if (t >= 1) begin
        check_eq($sformatf("stall_valid_c%0d", t), 32'(bus.out_valid), (t == 7) ? 32'h1 : 32'h0);
        check_eq($sformatf("stall_color_c%0d", t), 32'(bus.output_color),
                 (t == 7 || t == 8) ? 32'hFA50 : 32'(last_exp));
      end
      bus.stall = (t >= 2 && t <= 4);
      if (t == 0) begin
        drive_px(2'b00, 1'b1, 16'hFA50, 16'hF123);
      end else if (t >= 2 && t <= 4) begin
        drive_px(2'b00, 1'b1, 16'h7C00, 16'hF400);
      end else begin
        drive_idle();
      end
    end
    last_exp = 16'hFA50;

    // Stall while the output is valid: out_valid and colour must hold
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (t >= 4) begin
        check_eq($sformatf("hold_valid_c%0d", t), 32'(bus.out_valid), (t <= 6) ? 32'h1 : 32'h0);
        check_eq($sformatf("hold_color_c%0d", t), 32'(bus.output_color), 32'hF800);
      end
      bus.stall = (t == 4 || t == 5);
      if (t == 0) drive_px(2'b00, 1'b1, 16'h7C00, 16'hF400);
      else        drive_idle();
    end
    last_exp = 16'hF800;

    // Reset with three pixels in flight
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      drive_px(2'b00, 1'b1, 16'hFA50, 16'hF123);
    end
    @(negedge clk);
    drive_idle();
    check_eq("pre_reset_color", 32'(bus.output_color), 32'(last_exp));
    #2 reset = 1'b1;
    #1;
    check_eq("async_reset_valid", 32'(bus.out_valid), 32'h0);
    check_eq("async_reset_color", 32'(bus.output_color), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("post_reset_valid_c0", 32'(bus.out_valid), 32'h0);
    // First edge after release accepts a new pixel
    drive_px(2'b00, 1'b1, 16'h7C00, 16'hF400);
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      drive_idle();
      check_eq($sformatf("post_reset_valid_c%0d", t), 32'(bus.out_valid), (t == 4) ? 32'h1 : 32'h0);
      check_eq($sformatf("post_reset_color_c%0d", t), 32'(bus.output_color),
               (t >= 4) ? 32'hF800 : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
